control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Hardwired control unit that drives the Datapath register-transfer strobes (PC_Out, MAR_In, IncPC, Read, MDR_In, IR_In, Y_In, ZLO_In, ZLO_Out, per-register in/out, ALU CONTROL).
- Performs the T0–T2 fetch, then the opcode-dependent T3–T5 execute, instead of a bench hand-driving each strobe.
- Sits beside the Datapath; consumes IR contents and a memory-wait count.

Parameters:
- MEM_WAIT, 0, extra cycles T1 is held for memory read (0–7).
- NREGS, 16, number of general registers; one-hot register strobe width.

Ports:
- Clock  in  1  system clock, rising edge.
- Clear  in  1  reset, asynchronous, active-high.
- Start  in  1  leave IDLE and begin fetching.
- IR  in  32  instruction register contents. Fields: opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], Rc IR[18:15].
- PC_Out, MDR_Out, ZLO_Out, ZHI_Out  out  1 each  bus drivers.
- PC_In, MDR_In, MAR_In, IR_In, Y_In, ZLO_In, HI_In, LO_In  out  1 each  register loads.
- IncPC, Read  out  1 each  PC increment, memory read.
- R_Out  out  NREGS  one-hot register-to-bus.
- R_In  out  NREGS  one-hot bus-to-register.
- CONTROL  out  5  ALU function code.
- Running  out  1  high outside IDLE/HALT.
- Illegal  out  1  one-cycle pulse on unsupported opcode.

Behaviour:
- Reset: Clear=1 forces state IDLE immediately. All outputs are 0, CONTROL=00000, and the wait counter is 0. Clear mid-instruction aborts it with no partial strobes afterwards.
- Output timing (Moore): outputs depend only on the state register, the wait counter and IR. They change only after a rising Clock and are held for the whole cycle.
- States: IDLE, T0, T1, T2, T3, T4, T5, (T6 with macro), HALT.
- IDLE: all outputs 0. Start=1 sampled on a rising edge -> T0.
- T0: PC_Out, MAR_In, IncPC, ZLO_In -> T1.
- T1: ZLO_Out, PC_In, Read, MDR_In.
  - Held for 1+MEM_WAIT cycles using a 3-bit counter, cleared on exit.
  - All four strobes stay asserted through every cycle of T1.
  - -> T2.
- T2: MDR_Out, IR_In -> T3. IR is valid from T3 onward.
- T3 decode, by opcode:
  - 3-reg ALU (add 00011, sub 00100, and 00101, or 00110, shl 01000): R_Out[Rb], Y_In -> T4.
  - Unary (neg 10000, not 10001): R_Out[Rb], Y_In -> T4.
  - nop 11010: no strobes -> T0.
  - halt 11011: no strobes -> HALT.
  - Any other opcode: Illegal=1 for this cycle, no strobes -> T0.
- T4, 3-reg ops: R_Out[Rc], ZLO_In, CONTROL=opcode value.
- T4, unary ops: ZLO_In only; CONTROL=01010 (neg) or 01011 (not). No R_Out.
- T4 -> T5 in both cases.
- T5: ZLO_Out, R_In[Ra] -> T0. Next fetch starts with no idle cycle.
- HALT: all outputs 0, Running=0. Only Clear exits; Start is ignored.
- CONTROL is 00000 in every state except T4.
- R_Out and R_In are never both nonzero. At most one bit is set in each.
- Register index >= NREGS: strobe all-zero, Illegal pulses in T3, and sequencing continues normally.
- Start is ignored outside IDLE.

Optional Feature:
- Macro: CTRL_MULDIV_EN.
- Enabled: mul 01110 and div 01111 are legal.
  - T3: R_Out[Ra], Y_In.
  - T4: R_Out[Rb], CONTROL=opcode, ZLO_In (datapath loads ZHI and ZLO together).
  - T5: ZLO_Out, LO_In.
  - T6: ZHI_Out, HI_In -> T0.
- Disabled: T6 is not compiled. Ports ZHI_Out, HI_In and LO_In remain and are tied 0. Opcodes 01110/01111 take the Illegal path.

Test Plan:
- Clear=1, then 0, then Start=1, MEM_WAIT=0, IR=0x8A900000 (not R5,R2) -> T0..T5 in 6 cycles. Checks: T3 R_Out=0x0004 with Y_In; T4 CONTROL=01011 with ZLO_In; T5 R_In=0x0020 with ZLO_Out; then back to T0.
- IR=0x18918000 (add R1,R2,R3) -> T3 R_Out=0x0004; T4 R_Out=0x0008 with CONTROL=00011; T5 R_In=0x0002.
- MEM_WAIT=3 -> T1 strobes (ZLO_Out, PC_In, Read, MDR_In) held exactly 4 consecutive cycles, then T2.
- IR opcode 11011 -> HALT after T3, Running=0. Start pulse ignored; Clear returns to IDLE.
- Assert Clear during T4 of an add -> same-cycle all outputs 0. No R_In pulse follows; state IDLE.
- Opcode 01110: without the macro, Illegal pulses 1 cycle in T3 and the next state is T0. With CTRL_MULDIV_EN, T5 gives LO_In and T6 gives HI_In with ZHI_Out.

Source files
------------

// File: rtl/control_sequencer_if.sv
// Strobe/instruction bundle between control_sequencer and the datapath.
// master = sequencer side, slave = datapath side.
interface control_sequencer_if #(
    parameter int NREGS = 16
);
    logic             Start;
    logic [31:0]      IR;
    logic             PC_Out;
    logic             MDR_Out;
    logic             ZLO_Out;
    logic             ZHI_Out;
    logic             PC_In;
    logic             MDR_In;
    logic             MAR_In;
    logic             IR_In;
    logic             Y_In;
    logic             ZLO_In;
    logic             HI_In;
    logic             LO_In;
    logic             IncPC;
    logic             Read;
    logic [NREGS-1:0] R_Out;
    logic [NREGS-1:0] R_In;
    logic [4:0]       CONTROL;
    logic             Running;
    logic             Illegal;

    modport master (
        input  Start, IR,
        output PC_Out, MDR_Out, ZLO_Out, ZHI_Out,
        output PC_In, MDR_In, MAR_In, IR_In,
        output Y_In, ZLO_In, HI_In, LO_In,
        output IncPC, Read, R_Out, R_In,
        output CONTROL, Running, Illegal
    );

    modport slave (
        output Start, IR,
        input  PC_Out, MDR_Out, ZLO_Out, ZHI_Out,
        input  PC_In, MDR_In, MAR_In, IR_In,
        input  Y_In, ZLO_In, HI_In, LO_In,
        input  IncPC, Read, R_Out, R_In,
        input  CONTROL, Running, Illegal
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer driving datapath transfer strobes.
// Define CTRL_MULDIV_EN to add mul/div with a T6 HI writeback state.
module control_sequencer #(
    parameter int MEM_WAIT = 0,
    parameter int NREGS    = 16
) (
    input  logic                Clock,
    input  logic                Clear,
    control_sequencer_if.master bus
);
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;
    localparam logic [4:0] FN_NEG  = 5'b01010;
    localparam logic [4:0] FN_NOT  = 5'b01011;
    localparam logic [2:0] W_LAST  = 3'(MEM_WAIT);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5,
`ifdef CTRL_MULDIV_EN
        S_T6,
`endif
        S_HALT
    } state_t;

    state_t     r_state;
    logic [2:0] r_wait;

    logic [4:0]       w_op;
    logic [3:0]       w_ra;
    logic [3:0]       w_rb;
    logic [3:0]       w_rc;
    logic [NREGS-1:0] w_ra_oh;
    logic [NREGS-1:0] w_rb_oh;
    logic [NREGS-1:0] w_rc_oh;
    logic             w_ra_ok;
    logic             w_rb_ok;
    logic             w_rc_ok;
    logic             w_alu3;
    logic             w_unary;
    logic             w_md;
    logic             w_nop;
    logic             w_halt;
    logic             w_exec;
    logic             w_bad;
    logic             w_unused_ir;

    // Out-of-range indices decode to an all-zero strobe.
    function automatic logic [NREGS-1:0] onehot(input logic [3:0] idx);
        logic [NREGS-1:0] oh;
        for (int i = 0; i < NREGS; i++) begin
            oh[i] = (int'(idx) == i);
        end
        return oh;
    endfunction

    assign w_op        = bus.IR[31:27];
    assign w_ra        = bus.IR[26:23];
    assign w_rb        = bus.IR[22:19];
    assign w_rc        = bus.IR[18:15];
    assign w_unused_ir = ^bus.IR[14:0];

    assign w_ra_oh = onehot(w_ra);
    assign w_rb_oh = onehot(w_rb);
    assign w_rc_oh = onehot(w_rc);
    assign w_ra_ok = |w_ra_oh;
    assign w_rb_ok = |w_rb_oh;
    assign w_rc_ok = |w_rc_oh;

    assign w_alu3  = (w_op == OP_ADD) | (w_op == OP_SUB) |
                     (w_op == OP_AND) | (w_op == OP_OR)  |
                     (w_op == OP_SHL);
    assign w_unary = (w_op == OP_NEG) | (w_op == OP_NOT);
    assign w_nop   = (w_op == OP_NOP);
    assign w_halt  = (w_op == OP_HALT);
`ifdef CTRL_MULDIV_EN
    assign w_md    = (w_op == OP_MUL) | (w_op == OP_DIV);
`else
    assign w_md    = 1'b0;
`endif
    assign w_exec  = w_alu3 | w_unary | w_md;

    assign w_bad = ~(w_exec | w_nop | w_halt)
                 | (w_alu3  & ~(w_ra_ok & w_rb_ok & w_rc_ok))
                 | (w_unary & ~(w_ra_ok & w_rb_ok))
                 | (w_md    & ~(w_ra_ok & w_rb_ok));

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            r_state <= S_IDLE;
            r_wait  <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: if (bus.Start) r_state <= S_T0;
                S_T0:   r_state <= S_T1;
                S_T1: begin
                    if (r_wait == W_LAST) begin
                        r_wait  <= '0;
                        r_state <= S_T2;
                    end else begin
                        r_wait  <= r_wait + 3'd1;
                    end
                end
                S_T2:   r_state <= S_T3;
                S_T3: begin
                    if (w_exec)      r_state <= S_T4;
                    else if (w_halt) r_state <= S_HALT;
                    else             r_state <= S_T0;
                end
                S_T4:   r_state <= S_T5;
`ifdef CTRL_MULDIV_EN
                S_T5:   r_state <= w_md ? S_T6 : S_T0;
                S_T6:   r_state <= S_T0;
`else
                S_T5:   r_state <= S_T0;
`endif
                S_HALT: r_state <= S_HALT;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Decoded from state: IR is loaded on the T2 edge and T3 needs it.
    always_comb begin
        bus.PC_Out  = 1'b0;
        bus.MDR_Out = 1'b0;
        bus.ZLO_Out = 1'b0;
        bus.ZHI_Out = 1'b0;
        bus.PC_In   = 1'b0;
        bus.MDR_In  = 1'b0;
        bus.MAR_In  = 1'b0;
        bus.IR_In   = 1'b0;
        bus.Y_In    = 1'b0;
        bus.ZLO_In  = 1'b0;
        bus.HI_In   = 1'b0;
        bus.LO_In   = 1'b0;
        bus.IncPC   = 1'b0;
        bus.Read    = 1'b0;
        bus.R_Out   = '0;
        bus.R_In    = '0;
        bus.CONTROL = 5'b00000;
        bus.Running = (r_state != S_IDLE) && (r_state != S_HALT);
        bus.Illegal = 1'b0;
        unique case (r_state)
            S_T0: begin
                bus.PC_Out = 1'b1;
                bus.MAR_In = 1'b1;
                bus.IncPC  = 1'b1;
                bus.ZLO_In = 1'b1;
            end
            S_T1: begin
                bus.ZLO_Out = 1'b1;
                bus.PC_In   = 1'b1;
                bus.Read    = 1'b1;
                bus.MDR_In  = 1'b1;
            end
            S_T2: begin
                bus.MDR_Out = 1'b1;
                bus.IR_In   = 1'b1;
            end
            S_T3: begin
                bus.Illegal = w_bad;
                if (w_alu3 | w_unary) begin
                    bus.R_Out = w_rb_oh;
                    bus.Y_In  = 1'b1;
                end else if (w_md) begin
                    bus.R_Out = w_ra_oh;
                    bus.Y_In  = 1'b1;
                end
            end
            S_T4: begin
                bus.ZLO_In = 1'b1;
                if (w_alu3) begin
                    bus.R_Out   = w_rc_oh;
                    bus.CONTROL = w_op;
                end else if (w_md) begin
                    bus.R_Out   = w_rb_oh;
                    bus.CONTROL = w_op;
                end else if (w_unary) begin
                    bus.CONTROL = (w_op == OP_NEG) ? FN_NEG : FN_NOT;
                end
            end
            S_T5: begin
                bus.ZLO_Out = 1'b1;
                if (w_md) bus.LO_In = 1'b1;
                else      bus.R_In  = w_ra_oh;
            end
`ifdef CTRL_MULDIV_EN
            S_T6: begin
                bus.ZHI_Out = 1'b1;
                bus.HI_In   = 1'b1;
            end
`endif
            default: ;
        endcase
    end
endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: fetch, execute, wait states,
// halt, abort by Clear, illegal/out-of-range decode.
module tb_control_sequencer;
    logic Clock;
    logic Clear;
    int   n_cmp;
    int   n_err;

    localparam logic [15:0] Z16 = 16'h0000;
    localparam logic [4:0]  Z5  = 5'b00000;
    localparam logic [15:0] S_T0 = 16'h824A;
    localparam logic [15:0] S_T1 = 16'h2C06;
    localparam logic [15:0] S_T2 = 16'h4102;

    control_sequencer_if #(.NREGS(16)) if0 ();
    control_sequencer_if #(.NREGS(16)) if3 ();
    control_sequencer_if #(.NREGS(4))  ifn ();

    control_sequencer #(.MEM_WAIT(0), .NREGS(16)) dut0 (
        .Clock(Clock), .Clear(Clear), .bus(if0.master)
    );
    control_sequencer #(.MEM_WAIT(3), .NREGS(16)) dut3 (
        .Clock(Clock), .Clear(Clear), .bus(if3.master)
    );
    control_sequencer #(.MEM_WAIT(0), .NREGS(4)) dutn (
        .Clock(Clock), .Clear(Clear), .bus(ifn.master)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    function automatic logic [52:0] ex(input logic [15:0] s,
                                       input logic [15:0] ro,
                                       input logic [15:0] ri,
                                       input logic [4:0]  c);
        return {s, ro, ri, c};
    endfunction

    function automatic logic [52:0] snap0();
        return {if0.PC_Out, if0.MDR_Out, if0.ZLO_Out, if0.ZHI_Out,
                if0.PC_In, if0.MDR_In, if0.MAR_In, if0.IR_In,
                if0.Y_In, if0.ZLO_In, if0.HI_In, if0.LO_In,
                if0.IncPC, if0.Read, if0.Running, if0.Illegal,
                if0.R_Out, if0.R_In, if0.CONTROL};
    endfunction

    function automatic logic [52:0] snap3();
        return {if3.PC_Out, if3.MDR_Out, if3.ZLO_Out, if3.ZHI_Out,
                if3.PC_In, if3.MDR_In, if3.MAR_In, if3.IR_In,
                if3.Y_In, if3.ZLO_In, if3.HI_In, if3.LO_In,
                if3.IncPC, if3.Read, if3.Running, if3.Illegal,
                if3.R_Out, if3.R_In, if3.CONTROL};
    endfunction

    function automatic logic [28:0] snapn();
        return {ifn.PC_Out, ifn.MDR_Out, ifn.ZLO_Out, ifn.ZHI_Out,
                ifn.PC_In, ifn.MDR_In, ifn.MAR_In, ifn.IR_In,
                ifn.Y_In, ifn.ZLO_In, ifn.HI_In, ifn.LO_In,
                ifn.IncPC, ifn.Read, ifn.Running, ifn.Illegal,
                ifn.R_Out, ifn.R_In, ifn.CONTROL};
    endfunction

    task automatic test_reset();
        Clear = 1'b1;
        repeat (2) step();
        n_cmp++;
        if (snap0() !== 53'd0) begin
            n_err++;
            $display("FAIL reset_held got %h exp %h", snap0(), 53'd0);
        end
        @(negedge Clock);
        Clear = 1'b0;
        step();
        n_cmp++;
        if (snap0() !== 53'd0) begin
            n_err++;
            $display("FAIL reset_idle got %h exp %h", snap0(), 53'd0);
        end
        n_cmp++;
        if (snap3() !== 53'd0) begin
            n_err++;
            $display("FAIL reset_idle3 got %h exp %h", snap3(), 53'd0);
        end
    endtask

    task automatic test_unary();
        logic [52:0] e [7];
        e = '{ex(S_T0, Z16, Z16, Z5), ex(S_T1, Z16, Z16, Z5),
              ex(S_T2, Z16, Z16, Z5), ex(16'h0082, 16'h0004, Z16, Z5),
              ex(16'h0042, Z16, Z16, 5'b01011),
              ex(16'h2002, Z16, 16'h0020, Z5), ex(S_T0, Z16, Z16, Z5)};
        if0.IR = 32'h8A900000;
        if0.Start = 1'b1;
        step();
        if0.Start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) step();
            n_cmp++;
            if (snap0() !== e[i]) begin
                n_err++;
                $display("FAIL unary_c%0d got %h exp %h", i, snap0(), e[i]);
            end
        end
    endtask

    task automatic test_add();
        logic [52:0] e [6];
        e = '{ex(S_T1, Z16, Z16, Z5), ex(S_T2, Z16, Z16, Z5),
              ex(16'h0082, 16'h0004, Z16, Z5),
              ex(16'h0042, 16'h0008, Z16, 5'b00011),
              ex(16'h2002, Z16, 16'h0002, Z5), ex(S_T0, Z16, Z16, Z5)};
        if0.IR = 32'h18918000;
        for (int i = 0; i < 6; i++) begin
            step();
            n_cmp++;
            if (snap0() !== e[i]) begin
                n_err++;
                $display("FAIL add_c%0d got %h exp %h", i, snap0(), e[i]);
            end
        end
    endtask

    task automatic test_muldiv_opcode();
`ifdef CTRL_MULDIV_EN
        logic [52:0] e [7];
        e = '{ex(S_T1, Z16, Z16, Z5), ex(S_T2, Z16, Z16, Z5),
              ex(16'h0082, 16'h0002, Z16, Z5),
              ex(16'h0042, 16'h0004, Z16, 5'b01110),
              ex(16'h2012, Z16, Z16, Z5), ex(16'h1022, Z16, Z16, Z5),
              ex(S_T0, Z16, Z16, Z5)};
`else
        logic [52:0] e [4];
        e = '{ex(S_T1, Z16, Z16, Z5), ex(S_T2, Z16, Z16, Z5),
              ex(16'h0003, Z16, Z16, Z5), ex(S_T0, Z16, Z16, Z5)};
`endif
        if0.IR = 32'h70918000;
        foreach (e[i]) begin
            step();
            n_cmp++;
            if (snap0() !== e[i]) begin
                n_err++;
                $display("FAIL mul_c%0d got %h exp %h", i, snap0(), e[i]);
            end
        end
    endtask

    task automatic test_nop_and_undef();
        logic [52:0] e [8];
        logic [31:0] ir [2];
        e = '{ex(S_T1, Z16, Z16, Z5), ex(S_T2, Z16, Z16, Z5),
              ex(16'h0002, Z16, Z16, Z5), ex(S_T0, Z16, Z16, Z5),
              ex(S_T1, Z16, Z16, Z5), ex(S_T2, Z16, Z16, Z5),
              ex(16'h0003, Z16, Z16, Z5), ex(S_T0, Z16, Z16, Z5)};
        ir = '{32'hD0000000, 32'h38000000};
        for (int i = 0; i < 8; i++) begin
            if (i % 4 == 0) if0.IR = ir[i / 4];
            step();
            n_cmp++;
            if (snap0() !== e[i]) begin
                n_err++;
                $display("FAIL nopundef_c%0d got %h exp %h", i, snap0(), e[i]);
            end
        end
    endtask

    task automatic test_halt();
        logic [52:0] e [4];
        e = '{ex(S_T1, Z16, Z16, Z5), ex(S_T2, Z16, Z16, Z5),
              ex(16'h0002, Z16, Z16, Z5), ex(Z16, Z16, Z16, Z5)};
        if0.IR = 32'hD8000000;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if (snap0() !== e[i]) begin
                n_err++;
                $display("FAIL halt_c%0d got %h exp %h", i, snap0(), e[i]);
            end
        end
        if0.Start = 1'b1;
        repeat (2) step();
        if0.Start = 1'b0;
        n_cmp++;
        if (snap0() !== 53'd0) begin
            n_err++;
            $display("FAIL halt_start got %h exp %h", snap0(), 53'd0);
        end
        Clear = 1'b1;
        step();
        Clear = 1'b0;
        step();
        n_cmp++;
        if (snap0() !== 53'd0) begin
            n_err++;
            $display("FAIL halt_clear got %h exp %h", snap0(), 53'd0);
        end
        if0.Start = 1'b1;
        step();
        if0.Start = 1'b0;
        n_cmp++;
        if (snap0() !== ex(S_T0, Z16, Z16, Z5)) begin
            n_err++;
            $display("FAIL halt_restart got %h exp %h", snap0(),
                     ex(S_T0, Z16, Z16, Z5));
        end
    endtask

    task automatic test_clear_abort();
        if0.IR = 32'h18918000;
        repeat (4) step();
        n_cmp++;
        if (snap0() !== ex(16'h0042, 16'h0008, Z16, 5'b00011)) begin
            n_err++;
            $display("FAIL abort_t4 got %h exp %h", snap0(),
                     ex(16'h0042, 16'h0008, Z16, 5'b00011));
        end
        #2;
        Clear = 1'b1;
        #1;
        n_cmp++;
        if (snap0() !== 53'd0) begin
            n_err++;
            $display("FAIL abort_same got %h exp %h", snap0(), 53'd0);
        end
        step();
        @(negedge Clock);
        Clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (snap0() !== 53'd0) begin
                n_err++;
                $display("FAIL abort_after%0d got %h exp %h", i, snap0(), 53'd0);
            end
        end
    endtask

    task automatic test_mem_wait();
        logic [52:0] e [6];
        e = '{ex(S_T0, Z16, Z16, Z5), ex(S_T1, Z16, Z16, Z5),
              ex(S_T1, Z16, Z16, Z5), ex(S_T1, Z16, Z16, Z5),
              ex(S_T1, Z16, Z16, Z5), ex(S_T2, Z16, Z16, Z5)};
        if3.IR = 32'hD0000000;
        if3.Start = 1'b1;
        step();
        if3.Start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step();
            n_cmp++;
            if (snap3() !== e[i]) begin
                n_err++;
                $display("FAIL memwait_c%0d got %h exp %h", i, snap3(), e[i]);
            end
        end
    endtask

    task automatic test_reg_range();
        logic [28:0] e [7];
        e = '{{S_T0, 4'h0, 4'h0, Z5}, {S_T1, 4'h0, 4'h0, Z5},
              {S_T2, 4'h0, 4'h0, Z5}, {16'h0083, 4'h4, 4'h0, Z5},
              {16'h0042, 4'h0, 4'h0, 5'b01011},
              {16'h2002, 4'h0, 4'h0, Z5}, {S_T0, 4'h0, 4'h0, Z5}};
        ifn.IR = 32'h8A900000;
        ifn.Start = 1'b1;
        step();
        ifn.Start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) step();
            n_cmp++;
            if (snapn() !== e[i]) begin
                n_err++;
                $display("FAIL regrange_c%0d got %h exp %h", i, snapn(), e[i]);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        Clear = 1'b1;
        if0.Start = 1'b0;
        if0.IR = 32'h0;
        if3.Start = 1'b0;
        if3.IR = 32'h0;
        ifn.Start = 1'b0;
        ifn.IR = 32'h0;
        test_reset();
        test_unary();
        test_add();
        test_muldiv_opcode();
        test_nop_and_undef();
        test_halt();
        test_clear_abort();
        test_mem_wait();
        test_reg_range();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
